diferenca_sched: RTL

Round-robin scheduler that shares one 4-bit absolute-difference datapath (the team's existing diferenca unit: S=|A-B|, sinal=1 when A<B) between two requesters. It arbitrates requests and latches the winner's operands. It drives the shared datapath from registers, captures the magnitude and sign, and returns them through a valid/ready response handshake tagged with the requester id. It sits between the operand sources and the arithmetic datapath.

---
 rtl/diferenca_sched_pkg.sv | 12 +
 rtl/diferenca_sched_if.sv | 27 ++
 rtl/diferenca.sv | 12 +
 rtl/rr_arbiter2.sv | 17 +
 rtl/diferenca_sched.sv | 101 ++++++++++
 5 files changed

// File: rtl/diferenca_sched_pkg.sv
// rtl/diferenca_sched_pkg.sv - shared constants for the diferenca scheduler
package diferenca_sched_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

  // 2'b11 is unused and falls back to IDLE
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CALC = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

endpackage

// File: rtl/diferenca_sched_if.sv
// rtl/diferenca_sched_if.sv - request/response bundle between requesters and the scheduler
interface diferenca_sched_if;
  import diferenca_sched_pkg::*;

  logic [1:0]           req;
  logic [DEF_WIDTH-1:0] a0;
  logic [DEF_WIDTH-1:0] b0;
  logic [DEF_WIDTH-1:0] a1;
  logic [DEF_WIDTH-1:0] b1;
  logic [1:0]           ack;
  logic                 resp_valid;
  logic                 resp_ready;
  logic                 resp_id;
  logic [DEF_WIDTH-1:0] resp_s;
  logic                 resp_sinal;

  modport master (
    output req, a0, b0, a1, b1, resp_ready,
    input  ack, resp_valid, resp_id, resp_s, resp_sinal
  );

  modport slave (
    input  req, a0, b0, a1, b1, resp_ready,
    output ack, resp_valid, resp_id, resp_s, resp_sinal
  );

endinterface

// File: rtl/diferenca.sv
// rtl/diferenca.sv - 4-bit absolute difference: S=|A-B|, sinal=1 when A<B
module diferenca (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [3:0] S,
  output logic       sinal
);

  assign sinal = (A < B);
  assign S     = sinal ? (B - A) : (A - B);

endmodule

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant; ptr names the favoured requester on contention
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/diferenca_sched.sv
// rtl/diferenca_sched.sv - round-robin sharing of one diferenca datapath between two requesters
module diferenca_sched
  import diferenca_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  diferenca_sched_if.slave  bus,
  output logic              busy,
  output logic [CNT_W-1:0]  ops_cnt
);

  logic [1:0]       state;
  logic             ptr;
  logic             owner;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       ack_q;
  logic             resp_valid_q;
  logic             resp_id_q;
  logic [WIDTH-1:0] resp_s_q;
  logic             resp_sinal_q;
  logic [CNT_W-1:0] ops_cnt_q;

  logic [1:0]       grant;
  logic             winner;
  logic [WIDTH-1:0] dp_s;
  logic             dp_sinal;

  rr_arbiter2 u_arb (
    .req   (bus.req),
    .ptr   (ptr),
    .grant (grant)
  );

  assign winner = grant[1];

  // Datapath is fed only from the captured operands, so requesters may change inputs after ack
  diferenca u_dif (
    .A     (op_a),
    .B     (op_b),
    .S     (dp_s),
    .sinal (dp_sinal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      ptr          <= 1'b0;
      owner        <= 1'b0;
      op_a         <= '0;
      op_b         <= '0;
      ack_q        <= 2'b00;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_s_q     <= '0;
      resp_sinal_q <= 1'b0;
      ops_cnt_q    <= '0;
    end else begin
      ack_q <= 2'b00;
      case (state)
        ST_IDLE: begin
          if (|bus.req) begin
            op_a  <= winner ? bus.a1 : bus.a0;
            op_b  <= winner ? bus.b1 : bus.b0;
            owner <= winner;
            ack_q <= grant;
            ptr   <= ~winner;
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          resp_s_q     <= dp_s;
          resp_sinal_q <= dp_sinal;
          resp_id_q    <= owner;
          resp_valid_q <= 1'b1;
          state        <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            ops_cnt_q    <= ops_cnt_q + CNT_W'(1);
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ack        = ack_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_s     = resp_s_q;
  assign bus.resp_sinal = resp_sinal_q;
  assign busy           = (state != ST_IDLE);
  assign ops_cnt        = ops_cnt_q;

endmodule
